gate_truth_table_sequencer: RTL



---
 rtl/gate_tts_pkg.sv | 16 +
 rtl/gate_tts_dwell_timer.sv | 18 +
 rtl/gate_truth_table_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/gate_tts_pkg.sv
// gate_tts_pkg: shared states, output bit positions and golden gate model for the truth-table sequencer
package gate_tts_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam int Y_XOR = 0;
  localparam int Y_NOT = 1;
  localparam int Y_AND = 2;
  localparam int Y_OR  = 3;
  function automatic logic [3:0] expected_y(input logic [1:0] vec);
    logic [3:0] y;
    y[Y_XOR] = vec[0] ^ vec[1];
    y[Y_NOT] = ~vec[0];
    y[Y_AND] = vec[0] & vec[1];
    y[Y_OR]  = vec[0] | vec[1];
    return y;
  endfunction
endpackage

// File: rtl/gate_tts_dwell_timer.sv
// gate_tts_dwell_timer: dwell counter with clear/enable and terminal count at DWELL_CYCLES-1
module gate_tts_dwell_timer #(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt;
  // count while enabled, clear takes priority
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
  assign tc = cnt == CNT_W'(DWELL_CYCLES - 1);
endmodule

// File: rtl/gate_truth_table_sequencer.sv
// gate_truth_table_sequencer: sweeps x0/x1 through all vectors and checks gate outputs (optional err_cnt via GATE_TTS_ERR_CNT_EN)
module gate_truth_table_sequencer
  import gate_tts_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] dut_x,
  input  logic [3:0] dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] fail_vec,
`ifdef GATE_TTS_ERR_CNT_EN
  output logic [2:0] err_cnt,
`endif
  output logic [1:0] vec_idx
);
  state_t state, nxt;
  logic tc;
  logic [1:0] vec_n, fvec_n;
  logic [3:0] mask_n, mism;
  logic pass_n;
`ifdef GATE_TTS_ERR_CNT_EN
  logic [2:0] err_n;
`endif
  gate_tts_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state != DRIVE),
    .en (state == DRIVE),
    .tc (tc)
  );
  // next state and next values of the result registers
  always_comb begin
    nxt = state;
    vec_n = vec_idx;
    mask_n = fail_mask;
    fvec_n = fail_vec;
    pass_n = pass;
    mism = dut_y ^ expected_y(vec_idx);
`ifdef GATE_TTS_ERR_CNT_EN
    err_n = err_cnt;
`endif
    unique case (state)
      IDLE: if (start && !abort) begin
        nxt = DRIVE;
        vec_n = '0;
        mask_n = '0;
        fvec_n = '0;
        pass_n = 1'b0;
`ifdef GATE_TTS_ERR_CNT_EN
        err_n = '0;
`endif
      end
      DRIVE: nxt = abort ? IDLE : tc ? SAMPLE : DRIVE;
      SAMPLE: if (abort) nxt = IDLE;
      else begin
        mask_n = fail_mask | mism;
        fvec_n = (fail_mask == '0 && mism != '0) ? vec_idx : fail_vec;
        nxt = vec_idx == 2'd3 ? DONE : DRIVE;
        vec_n = vec_idx == 2'd3 ? vec_idx : vec_idx + 2'd1;
        pass_n = vec_idx == 2'd3 && mask_n == '0;
`ifdef GATE_TTS_ERR_CNT_EN
        err_n = err_cnt + 3'(mism != '0);
`endif
      end
      DONE: begin
        nxt = IDLE;
        pass_n = pass && !abort;
      end
    endcase
  end
  // register state and every output from the next-state decision
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      dut_x <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail_mask <= '0;
      fail_vec <= '0;
      vec_idx <= '0;
`ifdef GATE_TTS_ERR_CNT_EN
      err_cnt <= '0;
`endif
    end else begin
      state <= nxt;
      dut_x <= (nxt == DRIVE || nxt == SAMPLE) ? vec_n : '0;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      pass <= pass_n;
      fail_mask <= mask_n;
      fail_vec <= fvec_n;
      vec_idx <= vec_n;
`ifdef GATE_TTS_ERR_CNT_EN
      err_cnt <= err_n;
`endif
    end
endmodule
